// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and receiver:
//     - default frame geometry (data bits, stop-bit oversample ticks)
//     - oversample ticks per start/data bit (16x baud generator)
//     - 2-bit FSM state encoding
//     - a small constant helper for width calculations
// ---------------------------------------------------------------------------
package uart_pkg;

    // Default number of data bits per frame.
    localparam int NB_DATA_DEF = 8;

    // Default number of oversample ticks spent in the stop bit.
    localparam int N_TICKS_DEF = 16;

    // Start and data bits always last 16 ticks (16x oversampling).
    localparam int BIT_TICKS = 16;

    // Frame FSM encoding, common with the receiver.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_t;

    // Larger of two integers; used to size counters from parameters.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   Serial transmitter for 8N1-style frames, LSB first:
//     1 start bit (0), NB_DATA data bits, 1 stop bit (1).
//   Start and data bits last 16 oversample ticks each; the stop bit lasts
//   N_TICKS ticks. Timing comes from an external 16x baud tick.
//
// Parameters
//   NB_DATA  data bits per frame
//   N_TICKS  oversample ticks in the stop bit
//
// Ports
//   i_clk       system clock, rising edge
//   i_reset     synchronous, active-high reset
//   i_tick      one-clock baud pulse at 16x the bit rate
//   i_tx_start  level-sampled send request, honoured only when idle
//   i_din       byte to send, latched when the request is accepted
//   o_tx        serial line, idle high, straight from a flip-flop
//   o_tx_done   one-clock pulse in the first idle cycle after a frame
//   o_busy      high whenever the FSM is not idle
//
// Handshake: a request is accepted on any rising edge where the FSM is idle
// and i_tx_start is high; i_din is captured on that same edge. While o_busy
// is high both i_tx_start and i_din are ignored. The cycle with o_tx_done
// high is idle, so a held request starts the next frame on that edge.
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int N_TICKS = N_TICKS_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_din,
    output logic               o_tx,
    output logic               o_tx_done,
    output logic               o_busy
);

    // The tick counter is 4 bits for the 16-tick start/data bits; it grows
    // only when the stop bit needs more than 16 ticks.
    localparam int S_W = max_int(4, $clog2(N_TICKS));
    localparam int N_W = max_int(1, $clog2(NB_DATA));

    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(BIT_TICKS - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(N_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(NB_DATA - 1);

    uart_state_t        state_q, state_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;

    // -----------------------------------------------------------------------
    // State and datapath registers. Reset wins over every other input.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_tx_start) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (i_tick && (s_q == S_BIT_LAST)) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_tick && (s_q == S_BIT_LAST) && (n_q == N_LAST)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (i_tick && (s_q == S_STOP_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Tick counter, bit counter and shift register.
    // In IDLE the tick counter is held clear, so a tick arriving in the same
    // cycle the request is accepted is never counted.
    // -----------------------------------------------------------------------
    always_comb begin
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                s_d = '0;
                if (i_tx_start) begin
                    shift_d = i_din;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        n_d = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q != N_LAST) begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        s_d = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                s_d = '0;
                n_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic. The line value is decoded from the *next* state and
    // shift contents and then registered, so o_tx changes on the same edge
    // as the state and comes directly from a flip-flop.
    // -----------------------------------------------------------------------
    always_comb begin
        tx_d   = 1'b1;
        done_d = 1'b0;
        case (state_d)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        // Only a completed stop bit produces the done pulse; reset and
        // illegal-state recovery return to IDLE without one.
        if ((state_q == ST_STOP) && (state_d == ST_IDLE)) begin
            done_d = 1'b1;
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_done = done_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx.
//   dut_a: default geometry, tick every 4 clocks.
//   dut_b: N_TICKS=32 with the tick tied high.
//   A line monitor decodes dut_a frames and checks them against the
//   expected-byte queue filled by the stimulus.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  logic tick;
  assign tick = (cyc[1:0] == 2'b00);

  // ---------------- DUT A ----------------
  logic       a_start = 1'b0;
  logic [7:0] a_din   = 8'h00;
  logic       a_tx, a_done, a_busy;

  uart_tx #(.NB_DATA(8), .N_TICKS(16)) dut_a (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_tick     (tick),
    .i_tx_start (a_start),
    .i_din      (a_din),
    .o_tx       (a_tx),
    .o_tx_done  (a_done),
    .o_busy     (a_busy)
  );

  // ---------------- DUT B ----------------
  logic       b_start = 1'b0;
  logic [7:0] b_din   = 8'h00;
  logic       b_tx, b_done, b_busy;

  uart_tx #(.NB_DATA(8), .N_TICKS(32)) dut_b (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_tick     (1'b1),
    .i_tx_start (b_start),
    .i_din      (b_din),
    .o_tx       (b_tx),
    .o_tx_done  (b_done),
    .o_busy     (b_busy)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  int a_done_cnt = 0;

  always @(negedge clk) begin
    if (a_done === 1'b1) a_done_cnt <= a_done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- dut_a line monitor ----------------
  // Samples mid-bit (64 clocks per bit) from the first low cycle. A frame
  // that sees reset is dropped without consuming an expected byte.
  initial begin : a_monitor
    logic [7:0] rx;
    logic       aborted;
    int         idx;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || a_tx !== 1'b0) continue;
      rx      = '0;
      aborted = 1'b0;
      for (int k = 1; k <= 32 + 64 * 9; k++) begin
        @(negedge clk);
        if (reset === 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (k == 32) begin
          check_eq("sb_start_bit", a_tx, 1'b0);
        end else if (k > 32 && ((k - 32) % 64) == 0) begin
          idx = (k - 32) / 64;
          if (idx <= 8) rx[idx-1] = a_tx;
          else check_eq("sb_stop_bit", a_tx, 1'b1);
        end
      end
      if (!aborted) begin
        check_eq("sb_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check_eq("sb_byte", rx, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Raise a_start on a tick cycle so acceptance coincides with an
  // uncounted tick; returns at the first negedge after acceptance (j=0).
  task automatic a_launch(input logic [7:0] d, input logic hold);
    int g;
    g = 0;
    @(negedge clk);
    while (tick !== 1'b1 && g < 8) begin
      @(negedge clk);
      g++;
    end
    check_eq("tick_align", tick, 1'b1);
    a_din   = d;
    a_start = 1'b1;
    @(negedge clk);
    if (!hold) a_start = 1'b0;
  endtask

  // Checks a tick-aligned dut_a frame bit by bit from j=0; returns at j=640.
  task automatic a_check_frame(input logic [7:0] d, input string tag);
    logic [9:0] frame;
    int busy_cnt;
    frame    = {1'b1, d, 1'b0};
    busy_cnt = 0;
    for (int j = 0; j < 640; j++) begin
      if (a_busy === 1'b1) busy_cnt++;
      if ((j % 64) == 0 || (j % 64) == 63)
        check_eq($sformatf("%s_bit%0d_j%0d", tag, j / 64, j), a_tx, frame[j/64]);
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, busy_cnt, 640);
    check_eq({tag, "_end_busy"}, a_busy, 1'b0);
    check_eq({tag, "_end_done"}, a_done, 1'b1);
    check_eq({tag, "_end_tx"}, a_tx, 1'b1);
  endtask

  task automatic a_wait_idle(input string tag);
    int g;
    g = 0;
    while (a_busy !== 1'b0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check_eq({tag, "_idle_timeout"}, a_busy, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(10 * 50000);
    $display("FAIL watchdog: got timeout expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int done0;
    logic [8:0] b_bits;
    int stop_cnt;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_a_tx", a_tx, 1'b1);
    check_eq("rst_a_busy", a_busy, 1'b0);
    check_eq("rst_a_done", a_done, 1'b0);
    check_eq("rst_b_tx", b_tx, 1'b1);
    check_eq("rst_b_busy", b_busy, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 single frame: exact bit timing, one done pulse
    done0 = a_done_cnt;
    a_launch(8'hA5, 1'b0);
    exp_q.push_back(8'hA5);
    a_check_frame(8'hA5, "a5");
    @(negedge clk);
    check_eq("a5_done_one_cycle", a_done, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("a5_done_count", a_done_cnt - done0, 1);

    // Back-to-back: start held, 0x00 then 0xFF (din changed while busy)
    done0 = a_done_cnt;
    a_launch(8'h00, 1'b1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    a_din = 8'hFF;
    a_check_frame(8'h00, "b2b0");
    @(negedge clk);
    check_eq("b2b_second_busy", a_busy, 1'b1);
    check_eq("b2b_second_start_bit", a_tx, 1'b0);
    check_eq("b2b_done_gap", a_done, 1'b0);
    a_start = 1'b0;
    a_wait_idle("b2b");
    repeat (4) @(negedge clk);
    check_eq("b2b_done_count", a_done_cnt - done0, 2);

    // Mid-frame din change and start re-pulse are ignored
    done0 = a_done_cnt;
    a_launch(8'h3C, 1'b0);
    exp_q.push_back(8'h3C);
    repeat (200) @(negedge clk);
    a_din   = 8'hC3;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_wait_idle("mid");
    repeat (10) @(negedge clk);
    check_eq("mid_no_restart", a_busy, 1'b0);
    check_eq("mid_done_count", a_done_cnt - done0, 1);

    // Reset during data bit 4 of 0x55 (j 320..383)
    done0 = a_done_cnt;
    a_launch(8'h55, 1'b0);
    repeat (340) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_tx", a_tx, 1'b1);
    check_eq("rst_mid_busy", a_busy, 1'b0);
    check_eq("rst_mid_done", a_done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (700) @(negedge clk);
    check_eq("rst_mid_no_done", a_done_cnt - done0, 0);
    check_eq("rst_mid_line_idle", a_tx, 1'b1);
    a_launch(8'h55, 1'b0);
    exp_q.push_back(8'h55);
    a_check_frame(8'h55, "clean55");

    // Reset beats start and tick in the same cycle
    a_launch(8'h81, 1'b1);
    repeat (3) @(negedge clk);
    while (tick !== 1'b1) @(negedge clk);
    a_start = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    check_eq("rst_prio_busy", a_busy, 1'b0);
    check_eq("rst_prio_tx", a_tx, 1'b1);
    a_start = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check_eq("rst_prio_stay_idle", a_busy, 1'b0);
    repeat (10) @(negedge clk);

    // dut_b: tick tied high, 32-tick stop bit, loopback decode of 0x5A
    b_din   = 8'h5A;
    b_start = 1'b1;
    @(negedge clk);
    b_start  = 1'b0;
    b_bits   = '0;
    stop_cnt = 0;
    for (int j = 0; j <= 176; j++) begin
      if (j < 144 && (j % 16) == 8) b_bits[j/16] = b_tx;
      if (j >= 144 && j < 176 && b_tx === 1'b1 && b_busy === 1'b1) stop_cnt++;
      if (j == 143) check_eq("b_last_data_bit", b_tx, 1'b0);
      if (j == 144) check_eq("b_stop_begins", b_tx, 1'b1);
      if (j == 175) check_eq("b_stop_still_busy", b_busy, 1'b1);
      if (j == 176) begin
        check_eq("b_end_busy", b_busy, 1'b0);
        check_eq("b_rx_done", b_done, 1'b1);
      end
      if (j < 176) @(negedge clk);
    end
    check_eq("b_start_bit", b_bits[0], 1'b0);
    check_eq("b_loop_byte", b_bits[8:1], 8'h5A);
    check_eq("b_stop_clocks", stop_cnt, 32);

    repeat (20) @(negedge clk);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_uart_tx
